gppcu_scoreboard: RTL and testbench

Parametrised register scoreboard for the GPPCU issue stage, successor to the single-writeback stall generator. Keeps a per-register outstanding-write counter rather than a single busy bit, so several long-latency writes to one register can be in flight. Accepts NUMSRC source operands per instruction and NUMWB independent writeback ports. Exposes a valid/ready issue handshake and a sticky underflow error.

---
 rtl/gppcu_scoreboard_pkg.sv | 42 ++++
 rtl/gppcu_scoreboard_if.sv | 34 +++
 rtl/gppcu_scoreboard_entry.sv | 49 ++++
 rtl/gppcu_scoreboard.sv | 102 ++++++++++
 tb/tb_gppcu_scoreboard.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gppcu_scoreboard_pkg.sv
// Shared definitions for the GPPCU register scoreboard: width helper,
// default configuration widths, and the writeback match counter.
package gppcu_scoreboard_pkg;

  // Smallest bit count able to hold the value n (at least 1).
  function automatic int unsigned bit_fit(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((n >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

  // Default configuration and the widths derived from it.
  localparam int unsigned NUMREG_DEF  = 32;
  localparam int unsigned NUMWB_DEF   = 2;
  localparam int unsigned MAXPEND_DEF = 3;
  localparam int unsigned RBW = bit_fit(NUMREG_DEF - 1);
  localparam int unsigned CW  = bit_fit(MAXPEND_DEF);
  localparam int unsigned DW  = CW + bit_fit(NUMWB_DEF);

  // Fixed compare shape for popcount_match; callers zero-extend into it,
  // so configurations must keep NUMWB <= MAX_WB and RBW <= MAX_RBW.
  localparam int unsigned MAX_WB  = 8;
  localparam int unsigned MAX_RBW = 16;

  // Number of valid writeback ports naming regIdx; duplicates each count.
  function automatic logic [7:0] popcount_match(
    input logic [MAX_RBW-1:0]             regIdx,
    input logic [MAX_WB-1:0][MAX_RBW-1:0] wbRegs,
    input logic [MAX_WB-1:0]              wbValid
  );
    logic [7:0] cnt;
    cnt = '0;
    for (int p = 0; p < MAX_WB; p++) begin
      if (wbValid[p] && (wbRegs[p] == regIdx)) cnt = cnt + 8'd1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gppcu_scoreboard_if.sv
// Issue/writeback/status bundle between the GPPCU issue stage (master)
// and the register scoreboard (slave).
interface gppcu_scoreboard_if #(
  parameter int unsigned NUMREG = 32,
  parameter int unsigned NUMSRC = 3,
  parameter int unsigned NUMWB  = 2
);
  localparam int unsigned RBW = gppcu_scoreboard_pkg::bit_fit(NUMREG - 1);

  logic                    iFLUSH;
  logic                    iISSUE_VALID;
  logic                    oISSUE_READY;
  logic [RBW-1:0]          iDST;
  logic                    iDST_VALID;
  logic [NUMSRC*RBW-1:0]   iSRC;
  logic [NUMSRC-1:0]       iSRC_VALID;
  logic [NUMWB*RBW-1:0]    iWB_REG;
  logic [NUMWB-1:0]        iWB_VALID;
  logic [NUMREG-1:0]       oBUSY_MASK;
  logic                    oIDLE;
  logic                    oERR;

  modport master (
    output iFLUSH, iISSUE_VALID, iDST, iDST_VALID, iSRC, iSRC_VALID,
           iWB_REG, iWB_VALID,
    input  oISSUE_READY, oBUSY_MASK, oIDLE, oERR
  );

  modport slave (
    input  iFLUSH, iISSUE_VALID, iDST, iDST_VALID, iSRC, iSRC_VALID,
           iWB_REG, iWB_VALID,
    output oISSUE_READY, oBUSY_MASK, oIDLE, oERR
  );
endinterface

// File: rtl/gppcu_scoreboard_entry.sv
// One register's outstanding-write counter. Adds the issue occupy,
// subtracts the retirements, clamps at zero and flags an underflow.
module gppcu_sb_entry
  import gppcu_scoreboard_pkg::*;
#(
  parameter int unsigned MAXPEND = 3,
  parameter int unsigned NUMWB   = 2,
  localparam int unsigned ECW    = bit_fit(MAXPEND),
  localparam int unsigned DECW   = bit_fit(NUMWB)
) (
  input  logic            iACLK,
  input  logic            iRST,
  input  logic            inc,
  input  logic [DECW-1:0] dec,
  input  logic            flush,
  output logic [ECW-1:0]  pend,
  output logic            busy,
  output logic            underflow
);
  localparam int unsigned EDW = ECW + DECW;

  logic [EDW-1:0] sum;
  logic [ECW-1:0] pendNext;

  // Net count after this cycle's occupy and retirements.
  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    sum       = EDW'(pend) + EDW'(inc);
    pendNext  = '0;
    underflow = 1'b0;
    if (flush) begin
      pendNext = '0;
    end else if (sum >= EDW'(dec)) begin
      // Issue is blocked at MAXPEND, so the net result always fits ECW bits.
      pendNext = ECW'(sum - EDW'(dec));
    end else begin
      underflow = 1'b1;
    end
  end

  // Counter register; reset discards all outstanding writes at once.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iACLK or posedge iRST) begin
    if (iRST) pend <= '0;
    else      pend <= pendNext;
  end

  assign busy = (pend != '0);
endmodule

// File: rtl/gppcu_scoreboard.sv
// GPPCU issue-stage register scoreboard: per-register pending-write
// counters, RAW/WAW/saturation hazard check and sticky underflow error.
// Optional macro GPPCU_SCOREBOARD_WB_BYPASS_EN: hazard checks see this
// cycle's writebacks (same-cycle read-after-writeback).
module gppcu_scoreboard
  import gppcu_scoreboard_pkg::*;
#(
  parameter int unsigned NUMREG    = 32,
  parameter int unsigned NUMSRC    = 3,
  parameter int unsigned NUMWB     = 2,
  parameter int unsigned MAXPEND   = 3,
  parameter int unsigned WAW_STALL = 0
) (
  input logic               iACLK,
  input logic               iRST,
  gppcu_scoreboard_if.slave sb
);
  localparam int unsigned TRBW  = bit_fit(NUMREG - 1);
  localparam int unsigned TCW   = bit_fit(MAXPEND);
  localparam int unsigned TDECW = bit_fit(NUMWB);
  localparam int unsigned TDW   = TCW + TDECW;

  logic [MAX_WB-1:0][MAX_RBW-1:0] wbRegsX;
  logic [MAX_WB-1:0]              wbValidX;
  logic [NUMREG-1:0][TCW-1:0]     pend;
  logic [NUMREG-1:0][TCW-1:0]     effPend;
  logic [NUMREG-1:0]              busy;
  logic [NUMREG-1:0]              effBusy;
  logic [NUMREG-1:0]              underflow;
  logic                           raw, sat, waw, fire, err;
  logic [TRBW-1:0]                srcReg;

  // Widen the writeback ports into the shared compare shape.
  always_comb begin
    wbRegsX  = '0;
    wbValidX = '0;
    for (int p = 0; p < NUMWB; p++) begin
      wbRegsX[p]  = MAX_RBW'(sb.iWB_REG[p*TRBW +: TRBW]);
      wbValidX[p] = sb.iWB_VALID[p];
    end
  end

  for (genvar r = 0; r < NUMREG; r++) begin : gEntry
    logic [TDECW-1:0] dec;
    logic             inc;

    assign dec = TDECW'(popcount_match(MAX_RBW'(r), wbRegsX, wbValidX));
    assign inc = fire && sb.iDST_VALID && (sb.iDST == TRBW'(r));

    gppcu_sb_entry #(
      .MAXPEND (MAXPEND),
      .NUMWB   (NUMWB)
    ) uEntry (
      .iACLK     (iACLK),
      .iRST      (iRST),
      .inc       (inc),
      .dec       (dec),
      .flush     (sb.iFLUSH),
      .pend      (pend[r]),
      .busy      (busy[r]),
      .underflow (underflow[r])
    );

`ifdef GPPCU_SCOREBOARD_WB_BYPASS_EN
    // Count seen by the hazard check after this cycle's retirements.
    assign effPend[r] = (TDW'(pend[r]) >= TDW'(dec)) ?
                        TCW'(TDW'(pend[r]) - TDW'(dec)) : '0;
`else
    assign effPend[r] = pend[r];
`endif
    assign effBusy[r] = (effPend[r] != '0);
  end

  // Hazard reduction over the source operands and the destination.
  always_comb begin
    raw    = 1'b0;
    sat    = 1'b0;
    waw    = 1'b0;
    srcReg = '0;
    for (int k = 0; k < NUMSRC; k++) begin
      srcReg = sb.iSRC[k*TRBW +: TRBW];
      if (sb.iSRC_VALID[k] && (32'(srcReg) < NUMREG) && effBusy[srcReg]) raw = 1'b1;
    end
    if (sb.iDST_VALID && (32'(sb.iDST) < NUMREG)) begin
      sat = (effPend[sb.iDST] == TCW'(MAXPEND));
      waw = (WAW_STALL != 0) && (effPend[sb.iDST] != '0);
    end
  end

  assign sb.oISSUE_READY = !(raw || sat || waw);
  assign fire            = sb.iISSUE_VALID && sb.oISSUE_READY;

  // Sticky error: any register retired more writes than it had pending.
  always_ff @(posedge iACLK or posedge iRST) begin
    if (iRST)            err <= 1'b0;
    else if (|underflow) err <= 1'b1;
  end

  assign sb.oBUSY_MASK = busy;
  assign sb.oIDLE      = ~|busy;
  assign sb.oERR       = err;
endmodule

// File: tb/tb_gppcu_scoreboard.sv
// Directed scoreboard bench for gppcu_scoreboard (default parameters).
// Expected busy mask / error are queued as stimulus is driven and popped
// one cycle later when the registered state is sampled.
module tb_gppcu_scoreboard;
  import gppcu_scoreboard_pkg::*;

  logic iACLK = 1'b0;
  logic iRST;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] mask;
    logic        err;
  } exp_t;

  exp_t expQ[$];

  gppcu_scoreboard_if #(.NUMREG(32), .NUMSRC(3), .NUMWB(2)) sbIf ();

  gppcu_scoreboard #(
    .NUMREG    (32),
    .NUMSRC    (3),
    .NUMWB     (2),
    .MAXPEND   (3),
    .WAW_STALL (0)
  ) dut (
    .iACLK (iACLK),
    .iRST  (iRST),
    .sb    (sbIf.slave)
  );

  always #5 iACLK = ~iACLK;

  function automatic logic [31:0] b(input int n);
    logic [31:0] one;
    one = 32'd1;
    return one << n;
  endfunction

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic checkVec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkReady(input string tag, input logic exp);
    #1;
    checkBit(tag, sbIf.oISSUE_READY, exp);
  endtask

  task automatic idleInputs();
    sbIf.iFLUSH       = 1'b0;
    sbIf.iISSUE_VALID = 1'b0;
    sbIf.iDST         = '0;
    sbIf.iDST_VALID   = 1'b0;
    sbIf.iSRC         = '0;
    sbIf.iSRC_VALID   = '0;
    sbIf.iWB_REG      = '0;
    sbIf.iWB_VALID    = '0;
  endtask

  task automatic issueDst(input int dst);
    sbIf.iISSUE_VALID = 1'b1;
    sbIf.iDST_VALID   = 1'b1;
    sbIf.iDST         = 5'(dst);
  endtask

  task automatic setSrc(input int k, input int r, input logic v);
    sbIf.iSRC[k*5 +: 5] = 5'(r);
    sbIf.iSRC_VALID[k]  = v;
  endtask

  task automatic wb(input int p, input int r);
    sbIf.iWB_REG[p*5 +: 5] = 5'(r);
    sbIf.iWB_VALID[p]      = 1'b1;
  endtask

  task automatic expectNext(input string tag, input logic [31:0] mask, input logic err);
    exp_t e;
    e.tag  = tag;
    e.mask = mask;
    e.err  = err;
    expQ.push_back(e);
  endtask

  // Clock one cycle, compare the queued expectation, return inputs to idle.
  task automatic tick();
    exp_t e;
    @(posedge iACLK);
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkVec({e.tag, "_mask"}, sbIf.oBUSY_MASK, e.mask);
      checkBit({e.tag, "_idle"}, sbIf.oIDLE, (e.mask == 32'd0));
      checkBit({e.tag, "_err"}, sbIf.oERR, e.err);
    end
    idleInputs();
  endtask

  initial begin
    iRST = 1'b1;
    idleInputs();
    repeat (2) @(posedge iACLK);
    #1;
    checkVec("rst_mask", sbIf.oBUSY_MASK, 32'd0);
    checkBit("rst_idle", sbIf.oIDLE, 1'b1);
    checkBit("rst_err", sbIf.oERR, 1'b0);
    checkReady("rst_ready", 1'b1);
    iRST = 1'b0;

    // Occupy r5 twice, then reset asynchronously mid-cycle.
    issueDst(5);
    checkReady("issue5_ready", 1'b1);
    expectNext("occ5a", b(5), 1'b0);
    tick();
    issueDst(5);
    expectNext("occ5b", b(5), 1'b0);
    tick();
    #2;
    iRST = 1'b1;
    #1;
    checkVec("arst_mask", sbIf.oBUSY_MASK, 32'd0);
    checkBit("arst_idle", sbIf.oIDLE, 1'b1);
    checkBit("arst_err", sbIf.oERR, 1'b0);
    @(posedge iACLK);
    #1;
    iRST = 1'b0;
    issueDst(5);
    expectNext("occ5_post", b(5), 1'b0);
    tick();
    wb(0, 5);
    expectNext("wb5", 32'd0, 1'b0);
    tick();

    // RAW stall on operand 0 and its release.
    issueDst(7);
    expectNext("occ7", b(7), 1'b0);
    tick();
    issueDst(8);
    setSrc(0, 7, 1'b1);
    checkReady("raw7_stall", 1'b0);
    expectNext("raw7_hold", b(7), 1'b0);
    tick();
    issueDst(8);
    setSrc(0, 7, 1'b1);
    wb(0, 7);
`ifdef GPPCU_SCOREBOARD_WB_BYPASS_EN
    checkReady("raw7_bypass", 1'b1);
    expectNext("raw7_fire", b(8), 1'b0);
    tick();
`else
    checkReady("raw7_wbcycle", 1'b0);
    expectNext("raw7_freed", 32'd0, 1'b0);
    tick();
    issueDst(8);
    setSrc(0, 7, 1'b1);
    checkReady("raw7_release", 1'b1);
    expectNext("raw7_fire", b(8), 1'b0);
    tick();
`endif
    wb(1, 8);
    expectNext("wb8", 32'd0, 1'b0);
    tick();

    // Operand 2 hazard; an invalid operand naming a busy register is ignored.
    issueDst(12);
    expectNext("occ12", b(12), 1'b0);
    tick();
    setSrc(2, 12, 1'b1);
    checkReady("raw12_op2", 1'b0);
    setSrc(2, 12, 1'b0);
    setSrc(1, 12, 1'b0);
    checkReady("raw12_invalid", 1'b1);
    expectNext("hold12", b(12), 1'b0);
    tick();
    wb(0, 12);
    expectNext("wb12", 32'd0, 1'b0);
    tick();

    // Saturation at MAXPEND=3.
    for (int i = 0; i < 3; i++) begin
      issueDst(3);
      expectNext("occ3", b(3), 1'b0);
      tick();
    end
    issueDst(3);
    checkReady("sat3_stall", 1'b0);
    expectNext("sat3_hold", b(3), 1'b0);
    tick();
    sbIf.iDST_VALID = 1'b1;
    sbIf.iDST       = 5'd3;
    wb(0, 3);
`ifdef GPPCU_SCOREBOARD_WB_BYPASS_EN
    checkReady("sat3_wbcycle", 1'b1);
`else
    checkReady("sat3_wbcycle", 1'b0);
`endif
    expectNext("sat3_dec", b(3), 1'b0);
    tick();
    issueDst(3);
    checkReady("sat3_release", 1'b1);
    expectNext("sat3_refill", b(3), 1'b0);
    tick();
    wb(0, 3);
    wb(1, 3);
    expectNext("dual3", b(3), 1'b0);
    tick();
    wb(0, 3);
    expectNext("last3", 32'd0, 1'b0);
    tick();

    // Dual writeback to r9: exact retirement, then underflow.
    issueDst(9);
    expectNext("occ9a", b(9), 1'b0);
    tick();
    issueDst(9);
    expectNext("occ9b", b(9), 1'b0);
    tick();
    wb(0, 9);
    wb(1, 9);
    expectNext("dual9_ok", 32'd0, 1'b0);
    tick();
    issueDst(9);
    expectNext("occ9c", b(9), 1'b0);
    tick();
    wb(0, 9);
    wb(1, 9);
    expectNext("dual9_under", 32'd0, 1'b1);
    tick();
    expectNext("err_sticky", 32'd0, 1'b1);
    tick();

    // Simultaneous issue and writeback on r4 nets to no change.
    issueDst(4);
    expectNext("occ4", b(4), 1'b1);
    tick();
    issueDst(4);
    wb(0, 4);
    checkReady("simul4_ready", 1'b1);
    expectNext("simul4", b(4), 1'b1);
    tick();
    wb(0, 4);
    expectNext("wb4", 32'd0, 1'b1);
    tick();

    // Flush clears everything, including an issue firing in the same cycle.
    issueDst(1);
    expectNext("occ1a", b(1), 1'b1);
    tick();
    issueDst(1);
    expectNext("occ1b", b(1), 1'b1);
    tick();
    issueDst(30);
    expectNext("occ30", b(1) | b(30), 1'b1);
    tick();
    sbIf.iFLUSH = 1'b1;
    issueDst(2);
    checkReady("flush_ready", 1'b1);
    expectNext("flush", 32'd0, 1'b1);
    tick();
    expectNext("post_flush", 32'd0, 1'b1);
    tick();

    // Only reset clears the sticky error.
    #2;
    iRST = 1'b1;
    #1;
    checkBit("final_rst_err", sbIf.oERR, 1'b0);
    checkBit("final_rst_idle", sbIf.oIDLE, 1'b1);
    @(posedge iACLK);
    #1;
    iRST = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
